// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the parallel pseudo-random generator and its
// checker: checker FSM state encoding, the default feedback mask and a
// next-word helper for 8-bit streams.
// ---------------------------------------------------------------------------
package lfsr_pkg;

  // Checker state: HUNT while searching for a self-consistent stream,
  // LOCKED once enough consecutive predictions have matched.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  localparam int unsigned LFSR_W       = 8;
  localparam logic [7:0]  DEFAULT_TAPS = 8'hB8;

  // Fibonacci step: shift left and insert the parity of the tapped bits
  // at the LSB. With DEFAULT_TAPS this walks x^8+x^6+x^5+x^4+1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur,
                                                  input logic [LFSR_W-1:0] taps);
    return {cur[LFSR_W-2:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/lfsr_checker_predict.sv
// ---------------------------------------------------------------------------
// lfsr_predict
// Purely combinational one-step LFSR predictor.
// Ports:
//   cur_i  [W-1:0]  current word
//   nxt_o  [W-1:0]  word the generator produces after cur_i
// ---------------------------------------------------------------------------
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] nxt_o
);

  // Same recurrence as the generator: shift left, feedback parity into bit 0.
  assign nxt_o = {cur_i[W-2:0], ^(cur_i & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// Consumer of the pseudo-random generator bus. Locks onto the stream by
// predicting each word from the previous one, counts mismatches once locked,
// measures the sequence period in valid samples and flags the all-zero
// lock-up word.
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   data_in_i       generator word
//   data_valid_i    data_in_i is a new sample this cycle
//   clr_i           synchronous clear of err_cnt, period_cnt, period_valid, stuck
//   locked_o        checker is LOCKED
//   err_pulse_o     previous valid sample mismatched while LOCKED
//   err_cnt_o       saturating mismatch count while LOCKED
//   period_cnt_o    last measured period in valid samples
//   period_valid_o  period_cnt_o holds a completed measurement
//   stuck_o         sticky: an all-zero word was received
// ---------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned  W         = 8,
  parameter logic [W-1:0] TAPS      = DEFAULT_TAPS,
  parameter int unsigned  LOCK_CNT  = 4,
  parameter int unsigned  ERR_LIMIT = 3,
  parameter int unsigned  CW        = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [W-1:0]  data_in_i,
  input  logic          data_valid_i,
  input  logic          clr_i,
  output logic          locked_o,
  output logic          err_pulse_o,
  output logic [CW-1:0] err_cnt_o,
  output logic [CW-1:0] period_cnt_o,
  output logic          period_valid_o,
  output logic          stuck_o
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(ERR_LIMIT + 1);

  lfsr_state_e   state_q;
  logic [W-1:0]  pred_q;
  logic [W-1:0]  pred_d;
  logic [W-1:0]  pred_src;
  logic          first_q;
  logic [GW-1:0] good_run_q;
  logic [BW-1:0] bad_run_q;
  logic [W-1:0]  ref_q;
  logic [CW-1:0] run_q;
  logic [CW-1:0] err_cnt_q;
  logic [CW-1:0] period_q;
  logic          period_valid_q;
  logic          stuck_q;
  logic          err_pulse_q;
  logic          pred_hit;
  logic          hunt_match;

  // In HUNT the predictor re-seeds from the received word; once LOCKED it
  // free-runs from its own previous prediction so a corrupted sample cannot
  // derail the following predictions.
  assign pred_src   = (state_q == LOCKED) ? pred_q : data_in_i;
  assign pred_hit   = (data_in_i == pred_q);
  assign hunt_match = pred_hit && !first_q;

  lfsr_predict #(
    .W    (W),
    .TAPS (TAPS)
  ) u_predict (
    .cur_i (pred_src),
    .nxt_o (pred_d)
  );

  // Single state machine plus all counters and flags. Nothing moves unless
  // data_valid_i is high; err_pulse defaults low every cycle. A clear is
  // applied last so it overrides any increment or stuck detection on the
  // same edge, while the error pulse itself still fires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= HUNT;
      pred_q         <= '0;
      first_q        <= 1'b1;
      good_run_q     <= '0;
      bad_run_q      <= '0;
      ref_q          <= '0;
      run_q          <= '0;
      err_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stuck_q        <= 1'b0;
      err_pulse_q    <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (data_valid_i) begin
        pred_q <= pred_d;
        if (data_in_i == '0) begin
          stuck_q <= 1'b1;
        end
        unique case (state_q)
          HUNT: begin
            first_q <= 1'b0;
            if (hunt_match) begin
              if (good_run_q == GW'(LOCK_CNT - 1)) begin
                state_q    <= LOCKED;
                ref_q      <= data_in_i;
                run_q      <= CW'(1);
                good_run_q <= '0;
                bad_run_q  <= '0;
              end else begin
                good_run_q <= good_run_q + GW'(1);
              end
            end else begin
              good_run_q <= '0;
            end
          end
          LOCKED: begin
            if (data_in_i == ref_q) begin
              period_q       <= run_q;
              period_valid_q <= 1'b1;
              run_q          <= CW'(1);
            end else if (run_q != '1) begin
              run_q <= run_q + CW'(1);
            end
            if (!pred_hit) begin
              err_pulse_q <= 1'b1;
              if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + CW'(1);
              end
              if (bad_run_q == BW'(ERR_LIMIT - 1)) begin
                state_q    <= HUNT;
                first_q    <= 1'b1;
                good_run_q <= '0;
                bad_run_q  <= '0;
              end else begin
                bad_run_q <= bad_run_q + BW'(1);
              end
            end else begin
              bad_run_q <= '0;
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
      if (clr_i) begin
        err_cnt_q      <= '0;
        period_q       <= '0;
        period_valid_q <= 1'b0;
        stuck_q        <= 1'b0;
      end
    end
  end

  assign locked_o       = (state_q == LOCKED);
  assign err_pulse_o    = err_pulse_q;
  assign err_cnt_o      = err_cnt_q;
  assign period_cnt_o   = period_q;
  assign period_valid_o = period_valid_q;
  assign stuck_o        = stuck_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Drives generator streams (clean, corrupted, gapped, zero words, random)
// into lfsr_checker and compares against a sample-level behavioural model.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_CNT  = 4;
  localparam int ERR_LIMIT = 3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  dataIn;
  logic        dataValid;
  logic        clr;
  logic        locked;
  logic        errPulse;
  logic [15:0] errCnt;
  logic [15:0] periodCnt;
  logic        periodValid;
  logic        stuck;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, in terms of samples rather than registers.
  bit mLocked, mFirst, mErrPulse, mPeriodValid, mStuck;
  int mPred, mGood, mBad, mRef, mErrCnt, mPeriod, sampleIdx, refIdx;
  int gCur;

  lfsr_checker #(
    .W         (8),
    .TAPS      (8'hB8),
    .LOCK_CNT  (LOCK_CNT),
    .ERR_LIMIT (ERR_LIMIT),
    .CW        (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .data_in_i      (dataIn),
    .data_valid_i   (dataValid),
    .clr_i          (clr),
    .locked_o       (locked),
    .err_pulse_o    (errPulse),
    .err_cnt_o      (errCnt),
    .period_cnt_o   (periodCnt),
    .period_valid_o (periodValid),
    .stuck_o        (stuck)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator step written arithmetically: double mod 256, add tap parity.
  function automatic int lfsrStep(input int cur);
    int masked;
    int ones;
    masked = cur & 'hB8;
    ones = 0;
    for (int b = 0; b < 8; b++) ones += (masked >> b) & 1;
    return ((cur * 2) % 256) + (ones % 2);
  endfunction

  function automatic int genWord();
    int w;
    w = gCur;
    gCur = lfsrStep(gCur);
    return w;
  endfunction

  task automatic modelReset();
    mLocked = 0; mFirst = 1; mErrPulse = 0; mPeriodValid = 0; mStuck = 0;
    mPred = 0; mGood = 0; mBad = 0; mRef = 0; mErrCnt = 0; mPeriod = 0;
    sampleIdx = 0; refIdx = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input int d, input bit v, input bit c);
    bit miss;
    mErrPulse = 0;
    if (v) begin
      sampleIdx++;
      if (d == 0) mStuck = 1;
      if (!mLocked) begin
        if (!mFirst && d == mPred) mGood++;
        else mGood = 0;
        mFirst = 0;
        mPred = lfsrStep(d);
        if (mGood == LOCK_CNT) begin
          mLocked = 1; mRef = d; refIdx = sampleIdx; mBad = 0; mGood = 0;
        end
      end else begin
        miss = (d != mPred);
        mPred = lfsrStep(mPred);
        if (d == mRef) begin
          mPeriod = sampleIdx - refIdx; refIdx = sampleIdx; mPeriodValid = 1;
        end
        if (miss) begin
          mErrPulse = 1;
          if (mErrCnt < 65535) mErrCnt++;
          mBad++;
          if (mBad == ERR_LIMIT) begin
            mLocked = 0; mFirst = 1; mGood = 0; mBad = 0;
          end
        end else begin
          mBad = 0;
        end
      end
    end
    if (c) begin
      mErrCnt = 0; mPeriod = 0; mPeriodValid = 0; mStuck = 0;
    end
  endtask

  // One clock of stimulus: drive on the falling edge, update the model on
  // the rising edge, leave outputs settled 1 ns later with inputs idle.
  task automatic driveSample(input int w, input bit v, input bit c);
    @(negedge clk);
    dataIn = 8'(w); dataValid = v; clr = c;
    @(posedge clk);
    modelStep(w, v, c);
    #1;
    dataValid = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dataIn = '0; dataValid = 1'b0; clr = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %0b want 0", locked); end
    checks++; if (errPulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_pulse got %0b want 0", errPulse); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got %0d want 0", errCnt); end
    checks++; if (periodCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_period_cnt got %0d want 0", periodCnt); end
    checks++; if (periodValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_period_valid got %0b want 0", periodValid); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("[TB] FAIL reset_stuck got %0b want 0", stuck); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock(input string tag);
    gCur = 1;
    for (int i = 1; i <= LOCK_CNT + 1; i++) begin
      driveSample(genWord(), 1, 0);
      checks++;
      if (locked !== (i == LOCK_CNT + 1)) begin
        errors++; $display("[TB] FAIL %s_lock_sample%0d got %0b want %0b", tag, i, locked, (i == LOCK_CNT + 1));
      end
    end
    for (int i = 0; i < 260; i++) begin
      driveSample(genWord(), 1, 0);
      checks++;
      if (locked !== 1'b1 || errPulse !== 1'b0) begin
        errors++; $display("[TB] FAIL %s_steady got locked=%0b err_pulse=%0b want 1/0", tag, locked, errPulse);
      end
    end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL %s_err_cnt got %0d want 0", tag, errCnt); end
    checks++; if (periodCnt !== 16'd255) begin errors++; $display("[TB] FAIL %s_period got %0d want 255", tag, periodCnt); end
    checks++; if (periodValid !== 1'b1) begin errors++; $display("[TB] FAIL %s_period_valid got %0b want 1", tag, periodValid); end
    checks++; if (periodCnt !== 16'(mPeriod)) begin errors++; $display("[TB] FAIL %s_period_model got %0d want %0d", tag, periodCnt, mPeriod); end
  endtask

  task automatic test_single_error();
    driveSample(genWord() ^ 1, 1, 0);
    checks++; if (errPulse !== 1'b1) begin errors++; $display("[TB] FAIL single_pulse got %0b want 1", errPulse); end
    checks++; if (errCnt !== 16'd1) begin errors++; $display("[TB] FAIL single_err_cnt got %0d want 1", errCnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL single_locked got %0b want 1", locked); end
    for (int i = 0; i < 6; i++) begin
      driveSample(genWord(), 1, 0);
      checks++;
      if (errPulse !== 1'b0 || errCnt !== 16'd1 || locked !== 1'b1) begin
        errors++; $display("[TB] FAIL single_recover got pulse=%0b cnt=%0d locked=%0b want 0/1/1", errPulse, errCnt, locked);
      end
    end
  endtask

  task automatic test_burst_error();
    driveSample(0, 0, 1);
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL burst_clr got %0d want 0", errCnt); end
    for (int i = 1; i <= ERR_LIMIT; i++) begin
      driveSample(genWord() ^ 1, 1, 0);
      checks++;
      if (errPulse !== 1'b1 || locked !== (i != ERR_LIMIT)) begin
        errors++; $display("[TB] FAIL burst_err%0d got pulse=%0b locked=%0b want 1/%0b", i, errPulse, locked, (i != ERR_LIMIT));
      end
    end
    checks++; if (errCnt !== 16'(ERR_LIMIT)) begin errors++; $display("[TB] FAIL burst_err_cnt got %0d want %0d", errCnt, ERR_LIMIT); end
    for (int i = 1; i <= LOCK_CNT + 1; i++) begin
      driveSample(genWord(), 1, 0);
      checks++;
      if (locked !== (i == LOCK_CNT + 1) || errPulse !== 1'b0) begin
        errors++; $display("[TB] FAIL burst_relock%0d got locked=%0b pulse=%0b want %0b/0", i, locked, errPulse, (i == LOCK_CNT + 1));
      end
    end
  endtask

  task automatic test_valid_gap();
    logic [15:0] cntBefore;
    for (int i = 0; i < 100; i++) driveSample(genWord(), 1, 0);
    cntBefore = errCnt;
    for (int i = 0; i < 5; i++) begin
      driveSample(int'($urandom_range(0, 255)), 0, 0);
      checks++;
      if (errPulse !== 1'b0 || locked !== 1'b1 || errCnt !== cntBefore) begin
        errors++; $display("[TB] FAIL gap_hold got pulse=%0b locked=%0b cnt=%0d want 0/1/%0d", errPulse, locked, errCnt, cntBefore);
      end
    end
    for (int i = 0; i < 200; i++) begin
      driveSample(genWord(), 1, 0);
      checks++;
      if (errPulse !== 1'b0) begin errors++; $display("[TB] FAIL gap_resume_pulse got %0b want 0", errPulse); end
    end
    checks++; if (periodCnt !== 16'd255) begin errors++; $display("[TB] FAIL gap_period got %0d want 255", periodCnt); end
    checks++; if (periodValid !== 1'b1) begin errors++; $display("[TB] FAIL gap_period_valid got %0b want 1", periodValid); end
  endtask

  task automatic test_stuck();
    void'(genWord());
    driveSample(0, 1, 0);
    checks++; if (stuck !== 1'b1) begin errors++; $display("[TB] FAIL stuck_set got %0b want 1", stuck); end
    checks++; if (errPulse !== mErrPulse) begin errors++; $display("[TB] FAIL stuck_pulse got %0b want %0b", errPulse, mErrPulse); end
    for (int i = 0; i < 10; i++) begin
      driveSample(genWord(), 1, 0);
      checks++;
      if (stuck !== 1'b1) begin errors++; $display("[TB] FAIL stuck_hold got %0b want 1", stuck); end
    end
    driveSample(0, 0, 1);
    checks++; if (stuck !== 1'b0) begin errors++; $display("[TB] FAIL clr_stuck got %0b want 0", stuck); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_err_cnt got %0d want 0", errCnt); end
    checks++; if (periodCnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_period got %0d want 0", periodCnt); end
    checks++; if (periodValid !== 1'b0) begin errors++; $display("[TB] FAIL clr_period_valid got %0b want 0", periodValid); end
  endtask

  task automatic test_async_reset();
    driveSample(genWord() ^ 1, 1, 0);
    checks++; if (errCnt !== 16'd1 || locked !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset got cnt=%0d locked=%0b want 1/1", errCnt, locked); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL async_locked got %0b want 0", locked); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL async_err_cnt got %0d want 0", errCnt); end
    checks++; if (periodCnt !== 16'd0 || periodValid !== 1'b0) begin errors++; $display("[TB] FAIL async_period got %0d/%0b want 0/0", periodCnt, periodValid); end
    checks++; if (stuck !== 1'b0 || errPulse !== 1'b0) begin errors++; $display("[TB] FAIL async_flags got stuck=%0b pulse=%0b want 0/0", stuck, errPulse); end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    test_lock("relock");
  endtask

  task automatic test_random();
    int w;
    bit v;
    bit c;
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      if (v) begin
        w = genWord();
        if ($urandom_range(0, 14) == 0) w = w ^ (1 << $urandom_range(0, 7));
      end else begin
        w = int'($urandom_range(0, 255));
      end
      driveSample(w, v, c);
      checks++;
      if (locked !== mLocked || errPulse !== mErrPulse || stuck !== mStuck) begin
        errors++; $display("[TB] FAIL rand_flags@%0d got l=%0b p=%0b s=%0b want %0b/%0b/%0b", i, locked, errPulse, stuck, mLocked, mErrPulse, mStuck);
      end
      checks++;
      if (errCnt !== 16'(mErrCnt)) begin errors++; $display("[TB] FAIL rand_err_cnt@%0d got %0d want %0d", i, errCnt, mErrCnt); end
      checks++;
      if (periodCnt !== 16'(mPeriod) || periodValid !== mPeriodValid) begin
        errors++; $display("[TB] FAIL rand_period@%0d got %0d/%0b want %0d/%0b", i, periodCnt, periodValid, mPeriod, mPeriodValid);
      end
    end
  endtask

  // Bound the whole run so a stalled clock can never hang the simulation.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_lock("lock");
    test_single_error();
    test_burst_error();
    test_valid_gap();
    test_stuck();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
